// File: rtl/jtag_pkg.sv
// Shared opcode constants, one-hot decode and parameter-legality helpers for the
// JTAG user-register bank.
package jtag_pkg;

  localparam int OP_NOOP    = 0;
  localparam int MAX_IR_W   = 8;
  localparam int MAX_FUNC_W = 1 << MAX_IR_W;

  function automatic int op_dsy(input int nreg);
    return nreg + 1;
  endfunction

  function automatic logic [MAX_FUNC_W-1:0] onehot(input logic [MAX_IR_W-1:0] op);
    return MAX_FUNC_W'(1) << op;
  endfunction

  function automatic bit params_ok(input int nreg, input int reg_w, input int ir_w);
    bit ok;
    ok = 1'b1;
    if (nreg < 1 || nreg > 14)     ok = 1'b0;
    if (reg_w < 1 || reg_w > 32)   ok = 1'b0;
    if (ir_w < 2 || ir_w > MAX_IR_W) ok = 1'b0;
    else if ((1 << ir_w) < nreg + 2) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// Two-flop synchroniser for raw BSCAN signals; with EDGE set it adds a third
// stage and outputs a one-cycle rising-edge pulse instead of the level.
module jtag_edge_sync #(
  parameter int W    = 1,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic [W-1:0] s3_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s3_q <= '0;
        else        s3_q <= s2_q;
      end
      assign q = s2_q & ~s3_q;
    end else begin : g_level
      assign q = s2_q;
    end
  endgenerate

endmodule

// File: rtl/jtag_user_bank.sv
// JTAG USER1 instruction decoder plus NREG user registers on USER2, all sampled
// in the CLK25 domain. Optional macro JTAG_READBACK_EN: CAPTURE loads PO into
// the selected shift register(s) so a scan reads back live contents.
module jtag_user_bank
  import jtag_pkg::*;
#(
  parameter int NREG  = 4,
  parameter int REG_W = 8,
  parameter int IR_W  = 4,
  parameter logic [NREG*REG_W-1:0] DEF_VALUES = '0
) (
  input  logic                   CLK25,
  input  logic                   RST_B,
  input  logic                   DRCK1,
  input  logic                   DRCK2,
  input  logic                   SEL1,
  input  logic                   SEL2,
  input  logic                   SHIFT,
  input  logic                   CAPTURE,
  input  logic                   UPDATE,
  input  logic                   TDI,
  output logic                   TDO1,
  output logic                   TDO2,
  output logic [(1<<IR_W)-1:0]   FUNC,
  output logic [NREG*REG_W-1:0]  PO,
  output logic [NREG-1:0]        UPD_STB
);

  localparam int FUNC_W = 1 << IR_W;
  localparam int BANK_W = NREG * REG_W;
  localparam int DSY    = op_dsy(NREG);

  generate
    if (!params_ok(NREG, REG_W, IR_W)) begin : g_bad_params
      $error("jtag_user_bank: illegal NREG/REG_W/IR_W combination");
    end
  endgenerate

  logic [3:0] edge_rise;
  logic [3:0] lvl;
  logic       drck1_rise, drck2_rise, cap_rise, upd_rise;
  logic       sel1_s, sel2_s, shift_s, tdi_s;

  jtag_edge_sync #(.W(4), .EDGE(1'b1)) u_edge_sync (
    .clk   (CLK25),
    .rst_n (RST_B),
    .d     ({UPDATE, CAPTURE, DRCK2, DRCK1}),
    .q     (edge_rise)
  );

  jtag_edge_sync #(.W(4), .EDGE(1'b0)) u_level_sync (
    .clk   (CLK25),
    .rst_n (RST_B),
    .d     ({TDI, SHIFT, SEL2, SEL1}),
    .q     (lvl)
  );

  assign {upd_rise, cap_rise, drck2_rise, drck1_rise} = edge_rise;
  assign {tdi_s, shift_s, sel2_s, sel1_s}             = lvl;

  logic [IR_W-1:0]   ir_sr_q,   ir_sr_d;
  logic [FUNC_W-1:0] func_q,    func_d;
  logic [BANK_W-1:0] sr_q,      sr_d;
  logic [BANK_W-1:0] po_q,      po_d;
  logic [NREG-1:0]   upd_stb_q, upd_stb_d;
  logic              tdo1_q,    tdo1_d;
  logic              tdo2_q,    tdo2_d;

  logic [NREG-1:0]   sel_reg;
  logic              dsy;

  // Opcodes 1..NREG map onto FUNC bits 1..NREG; DSY is the next bit up.
  assign sel_reg = func_q[NREG:1];
  assign dsy     = func_q[DSY];

  always_comb begin
    ir_sr_d   = ir_sr_q;
    func_d    = func_q;
    sr_d      = sr_q;
    po_d      = po_q;
    upd_stb_d = '0;
    tdo1_d    = ir_sr_q[0];
    tdo2_d    = 1'b0;

    if (upd_rise) begin
      if (sel1_s && !sel2_s) begin
        func_d = FUNC_W'(onehot(MAX_IR_W'(ir_sr_q)));
      end
      if (sel2_s && !sel1_s) begin
        for (int k = 0; k < NREG; k++) begin
          if (dsy || sel_reg[k]) begin
            po_d[k*REG_W +: REG_W] = sr_q[k*REG_W +: REG_W];
            upd_stb_d[k]           = 1'b1;
          end
        end
      end
    end else if (cap_rise) begin
`ifdef JTAG_READBACK_EN
      if (sel2_s) begin
        for (int k = 0; k < NREG; k++) begin
          if (dsy || sel_reg[k]) sr_d[k*REG_W +: REG_W] = po_q[k*REG_W +: REG_W];
        end
      end
`endif
    end else begin
      if (drck1_rise && sel1_s && shift_s) begin
        ir_sr_d = (ir_sr_q >> 1) | (IR_W'(tdi_s) << (IR_W - 1));
      end
      if (drck2_rise && sel2_s && shift_s) begin
        // The daisy chain is just the whole bank treated as one shift register.
        if (dsy) begin
          sr_d = (sr_q >> 1) | (BANK_W'(tdi_s) << (BANK_W - 1));
        end else begin
          for (int k = 0; k < NREG; k++) begin
            if (sel_reg[k]) begin
              sr_d[k*REG_W +: REG_W] = (sr_q[k*REG_W +: REG_W] >> 1)
                                     | (REG_W'(tdi_s) << (REG_W - 1));
            end
          end
        end
      end
    end

    if (dsy) begin
      tdo2_d = sr_q[0];
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (sel_reg[k]) tdo2_d = sr_q[k*REG_W];
      end
    end
  end

  always_ff @(posedge CLK25 or negedge RST_B) begin
    if (!RST_B) begin
      ir_sr_q   <= '0;
      func_q    <= FUNC_W'(1) << OP_NOOP;
      sr_q      <= DEF_VALUES;
      po_q      <= DEF_VALUES;
      upd_stb_q <= '0;
      tdo1_q    <= 1'b0;
      tdo2_q    <= 1'b0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      func_q    <= func_d;
      sr_q      <= sr_d;
      po_q      <= po_d;
      upd_stb_q <= upd_stb_d;
      tdo1_q    <= tdo1_d;
      tdo2_q    <= tdo2_d;
    end
  end

  assign TDO1    = tdo1_q;
  assign TDO2    = tdo2_q;
  assign FUNC    = func_q;
  assign PO      = po_q;
  assign UPD_STB = upd_stb_q;

endmodule

// File: tb/tb_jtag_user_bank.sv
// Directed bench for jtag_user_bank (NREG=4, REG_W=8, DEF_VALUES=32'h44332211).
module tb_jtag_user_bank;

  localparam int HALF = 5;
  localparam logic [31:0] DEF = 32'h44332211;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        drck1 = 1'b0, drck2 = 1'b0, sel1 = 1'b0, sel2 = 1'b0;
  logic        shift = 1'b0, capture = 1'b0, update = 1'b0, tdi = 1'b0;
  logic        tdo1, tdo2;
  logic [15:0] func;
  logic [31:0] po;
  logic [3:0]  upd_stb;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] scan_out;
  logic [3:0]  stb_or;
  int          stb_n;
  logic [31:0] po_at;

  jtag_user_bank #(
    .NREG(4), .REG_W(8), .IR_W(4), .DEF_VALUES(DEF)
  ) dut (
    .CLK25   (clk),
    .RST_B   (rst_b),
    .DRCK1   (drck1),
    .DRCK2   (drck2),
    .SEL1    (sel1),
    .SEL2    (sel2),
    .SHIFT   (shift),
    .CAPTURE (capture),
    .UPDATE  (update),
    .TDI     (tdi),
    .TDO1    (tdo1),
    .TDO2    (tdo2),
    .FUNC    (func),
    .PO      (po),
    .UPD_STB (upd_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_drck1();
    @(negedge clk) drck1 = 1'b1;
    wait_cyc(HALF);
    drck1 = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic pulse_drck2();
    @(negedge clk) drck2 = 1'b1;
    wait_cyc(HALF);
    drck2 = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic pulse_capture();
    @(negedge clk) capture = 1'b1;
    wait_cyc(HALF);
    capture = 1'b0;
    wait_cyc(HALF);
  endtask

  // UPDATE pulse that records every strobe seen and PO in the strobe cycle.
  task automatic pulse_update(output logic [3:0] s_or, output int s_n, output logic [31:0] p_at);
    s_or = 4'h0;
    s_n  = 0;
    p_at = po;
    @(negedge clk) update = 1'b1;
    for (int i = 0; i < 2*HALF; i++) begin
      @(negedge clk);
      if (upd_stb != 4'h0) begin
        s_or = s_or | upd_stb;
        s_n++;
        p_at = po;
      end
    end
    update = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic ir_shift(input logic [3:0] op);
    sel1  = 1'b1;
    shift = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tdi = op[i];
      pulse_drck1();
    end
    shift = 1'b0;
  endtask

  task automatic ir_load(input logic [3:0] op);
    logic [3:0] s_or;
    int         s_n;
    logic [31:0] p_at;
    ir_shift(op);
    pulse_update(s_or, s_n, p_at);
    sel1 = 1'b0;
    wait_cyc(2);
  endtask

  task automatic dr_shift(input logic [31:0] data, input int n, output logic [31:0] out);
    out   = '0;
    sel2  = 1'b1;
    shift = 1'b1;
    for (int i = 0; i < n; i++) begin
      out[i] = tdo2;
      tdi    = data[i];
      pulse_drck2();
    end
    shift = 1'b0;
  endtask

  initial begin
    wait_cyc(4);
    check("rst_po", po, DEF);
    check("rst_func", 32'(func), 32'h0001);
    check("rst_stb", 32'(upd_stb), 32'h0);
    check("rst_tdo1", 32'(tdo1), 32'h0);
    check("rst_tdo2", 32'(tdo2), 32'h0);
    @(negedge clk) rst_b = 1'b1;
    wait_cyc(4);

    // Single register 2 via opcode 3
    ir_shift(4'd3);
    wait_cyc(2);
    check("ir3_tdo1", 32'(tdo1), 32'h1);
    pulse_update(stb_or, stb_n, po_at);
    sel1 = 1'b0;
    wait_cyc(2);
    check("op3_func", 32'(func), 32'h0008);
    dr_shift(32'h000000A5, 8, scan_out);
    check("op3_scanout", scan_out, 32'h00000033);
    pulse_update(stb_or, stb_n, po_at);
    sel2 = 1'b0;
    check("op3_po", po, 32'h44A52211);
    check("op3_stb", 32'(stb_or), 32'h4);
    check("op3_stb_len", 32'(stb_n), 32'd1);
    check("op3_po_with_stb", po_at, 32'h44A52211);

    // Daisy chain via opcode 5
    ir_load(4'd5);
    check("dsy_func", 32'(func), 32'h0020);
    dr_shift(32'hDEADBEEF, 32, scan_out);
    check("dsy_scanout", scan_out, 32'h44A52211);
    pulse_update(stb_or, stb_n, po_at);
    sel2 = 1'b0;
    check("dsy_po", po, 32'hDEADBEEF);
    check("dsy_stb", 32'(stb_or), 32'hF);
    check("dsy_stb_len", 32'(stb_n), 32'd1);

    // Fresh reset, then capture/readback behaviour on register 0
    @(negedge clk) rst_b = 1'b0;
    wait_cyc(2);
    @(negedge clk) rst_b = 1'b1;
    wait_cyc(4);
    ir_load(4'd1);
    check("op1_func", 32'(func), 32'h0002);
    dr_shift(32'h0000005A, 8, scan_out);
    check("op1_first_scan", scan_out, 32'h00000011);
    pulse_capture();
    dr_shift(32'h000000C3, 8, scan_out);
`ifdef JTAG_READBACK_EN
    check("capture_readback", scan_out, 32'h00000011);
`else
    check("capture_legacy", scan_out, 32'h0000005A);
`endif
    pulse_update(stb_or, stb_n, po_at);
    sel2 = 1'b0;
    check("op1_po", po, 32'h443322C3);
    check("op1_stb", 32'(stb_or), 32'h1);

    // Asynchronous reset in the middle of a scan
    sel2  = 1'b1;
    shift = 1'b1;
    tdi   = 1'b1;
    pulse_drck2();
    pulse_drck2();
    @(negedge clk) drck2 = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    check("async_rst_po", po, DEF);
    check("async_rst_func", 32'(func), 32'h0001);
    check("async_rst_tdo2", 32'(tdo2), 32'h0);
    check("async_rst_stb", 32'(upd_stb), 32'h0);
    drck2 = 1'b0; sel2 = 1'b0; shift = 1'b0; tdi = 1'b0;
    wait_cyc(3);
    @(negedge clk) rst_b = 1'b1;
    wait_cyc(4);

    // Unmapped opcode 9
    ir_load(4'd9);
    check("op9_func", 32'(func), 32'h0200);
    dr_shift(32'h0000BEEF, 16, scan_out);
    check("op9_tdo2", scan_out, 32'h0);
    pulse_update(stb_or, stb_n, po_at);
    sel2 = 1'b0;
    check("op9_po", po, DEF);
    check("op9_stb", 32'(stb_n), 32'd0);

    // UPDATE with both SEL1 and SEL2 is ignored
    ir_shift(4'd2);
    sel2 = 1'b1;
    pulse_update(stb_or, stb_n, po_at);
    sel1 = 1'b0;
    sel2 = 1'b0;
    wait_cyc(2);
    check("both_sel_func", 32'(func), 32'h0200);
    check("both_sel_stb", 32'(stb_n), 32'd0);
    check("both_sel_po", po, DEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtag_user_bank.md
# jtag_user_bank

Parametrised JTAG user-function register bank: the next generation of the CFEB JTAG instruction decoder and its fixed user registers. It decodes a USER1 opcode and provides NREG writable user registers, each REG_W bits wide with its own default value, on USER2. It adds capture-based readback, daisy-chain access to all registers, and per-register update strobes. All BSCAN signals are sampled and edge-detected in the CLK25 domain, so the block is single-clock and sits directly behind the BSCAN primitive.

## Interface
Parameters:
- NREG, 4: number of user registers, 1..14.
- REG_W, 8: width of every register, 1..32.
- IR_W, 4: opcode width; must satisfy 2**IR_W >= NREG+2.
- DEF_VALUES, 0: NREG*REG_W-bit concatenation of per-register defaults; register k occupies bits [k*REG_W +: REG_W].

Ports:
- CLK25  in  1  system clock; must be at least 8x the JTAG TCK rate.
- RST_B  in  1  asynchronous, active-low reset.
- DRCK1, DRCK2  in  1 each  raw BSCAN data-register clocks.
- SEL1, SEL2  in  1 each  USER1 / USER2 selected.
- SHIFT, CAPTURE, UPDATE  in  1 each  raw TAP state flags.
- TDI  in  1  serial test data in.
- TDO1  out  1  instruction shift-register LSB.
- TDO2  out  1  data-path serial out.
- FUNC  out  2**IR_W  one-hot decoded function.
- PO  out  NREG*REG_W  parallel register outputs.
- UPD_STB  out  NREG  one-cycle pulse per register on update.

## Operation
- Synchronisation: every raw input passes through 2 flops. Rising edges of DRCK1, DRCK2, CAPTURE and UPDATE are detected from the second and third flop stages.
- Instruction path: on a DRCK1 rise with SEL1 & SHIFT, the IR_W-bit ir_sr shifts right and TDI enters the MSB.
- Instruction update: on an UPDATE rise with SEL1, FUNC <= one-hot(ir_sr).
- Opcode map:
  - 0 is NoOp.
  - 1..NREG select register opcode-1.
  - NREG+1 (DSY) selects the daisy chain.
  - Every other opcode sets its FUNC bit and selects no register.
- Shift: on a DRCK2 rise with SEL2 & SHIFT, the selected shift register shifts right and TDI enters the MSB.
  - In DSY mode all NREG shift registers form one chain. TDI enters register NREG-1, each register's LSB feeds the MSB of register k-1, and register 0's LSB drives TDO2.
- Update: on an UPDATE rise with SEL2, the selected register's PO slice is loaded from its shift register and its UPD_STB bit pulses for one cycle. In DSY mode all registers load and all strobes pulse.
- No register selected: shift, capture and update have no effect and TDO2 = 0.
- TDO2 is the registered LSB of the selected or chained path.
- An UPDATE rise with both SEL1 and SEL2 asserted is ignored.
- Simultaneous edges are handled in this priority: UPDATE over CAPTURE over DRCK.

## Timing
- Reset values:
  - FUNC = 1 (NoOp).
  - ir_sr = 0.
  - Shift registers = DEF_VALUES.
  - PO = DEF_VALUES.
  - UPD_STB = 0.
  - TDO1 = TDO2 = 0.
- Latency: a raw edge takes effect on the 3rd CLK25 rising edge after it; TDO1/TDO2 settle 1 cycle after that.
- PO and UPD_STB change in the same cycle.
- A new opcode takes effect for the first DRCK2 edge after UPDATE, given TCK ≤ CLK25/8.
- RST_B asserted mid-shift aborts the scan; all state returns to reset values immediately, asynchronously.

## Configuration
- JTAG_READBACK_EN defined: on a CAPTURE rise with SEL2, each selected shift register (all of them in DSY mode) loads its current PO slice, so the next scan shifts out the live register contents.
- JTAG_READBACK_EN undefined: CAPTURE is ignored and shift registers keep their last shifted value. This matches legacy behaviour.

## Structure
- Package jtag_pkg holds:
  - OP_NOOP = 0.
  - The function op_dsy(NREG), returning NREG+1.
  - The function onehot(IR_W) decode.
  - Parameter-legality checks.
- Sub-module jtag_edge_sync contains the 2-flop synchroniser plus rising-edge detector. It is instantiated for DRCK1, DRCK2, CAPTURE and UPDATE; SEL1, SEL2, SHIFT and TDI use its level output.

## Test plan
All scenarios use NREG=4, REG_W=8, DEF_VALUES=32'h44332211.
- Reset -> PO=32'h44332211, FUNC=1, UPD_STB=0, TDO1=TDO2=0.
- USER1 opcode 3, then USER2 shift of 8'hA5, then UPDATE -> PO[23:16]=8'hA5 and UPD_STB=4'b0100 for one cycle; all other slices unchanged.
- Opcode 5 (DSY) and a 32-bit scan of 32'hDEADBEEF, then UPDATE -> PO=32'hDEADBEEF, UPD_STB=4'hF; the first 32 bits out of TDO2 are the prior shift contents, LSB first.
- JTAG_READBACK_EN defined, opcode 1, CAPTURE then 8 shifts -> TDO2 emits 8'h11 LSB first.
- JTAG_READBACK_EN undefined, same sequence -> TDO2 emits the last shifted data; with RST_B pulsed low during the shift -> PO returns to 32'h44332211 immediately.
- Opcode 9 (unmapped) with a 16-bit scan and UPDATE -> FUNC=16'h0200, PO unchanged, TDO2 held 0.
